// File: rtl/ad_multi_pkg.sv
// Shared definitions for the multi-channel ADC capture engine: register map,
// frame FSM encoding and register reset defaults.
package ad_multi_pkg;

  localparam logic [7:0] RegCtrl     = 8'h00;
  localparam logic [7:0] RegChEnLo   = 8'h01;
  localparam logic [7:0] RegChEnHi   = 8'h02;
  localparam logic [7:0] RegPeriodLo = 8'h03;
  localparam logic [7:0] RegPeriodHi = 8'h04;
  localparam logic [7:0] RegOvfLo    = 8'h05;
  localparam logic [7:0] RegOvfHi    = 8'h06;
  localparam logic [7:0] RegSclkDiv  = 8'h07;
  localparam logic [7:0] RegStat     = 8'h08;
  localparam logic [7:0] RegInfo     = 8'h09;

  localparam logic [15:0] PERIOD_RST   = 16'd1000;
  localparam logic [7:0]  SCLK_DIV_RST = 8'd1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StShift = 3'd2,
    StHold  = 3'd3,
    StLoad  = 3'd4
  } frame_state_e;

endpackage

// File: rtl/ad_rr_arb.sv
// NCH-way round-robin arbiter: grants the first requester at or after the
// start index, wrapping.
module ad_rr_arb #(
  parameter int unsigned NCH = 8,
  parameter int unsigned CHW = 4
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] start,
  output logic [CHW-1:0] gnt,
  output logic           any
);

  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;
  int unsigned      sum;

  always_comb begin
    dbl = {req, req} >> start;
    rot = dbl[NCH-1:0];
    gnt = '0;
    any = 1'b0;
    sum = 0;
    for (int unsigned p = 0; p < NCH; p++) begin
      if (!any && rot[p]) begin
        any = 1'b1;
        sum = 32'(start) + p;
        if (sum >= NCH) sum = sum - NCH;
        gnt = CHW'(sum);
      end
    end
  end

endmodule

// File: rtl/ad_multi_ch.sv
// N-channel simultaneous-sampling serial ADC capture engine with fx-bus
// register file and a round-robin merged valid/ready sample stream.
module ad_multi_ch
  import ad_multi_pkg::*;
#(
  parameter int unsigned NCH        = 8,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned DW         = 16,
  parameter int unsigned CHW        = 4
) (
  input  logic            clk_sys,
  input  logic            rst,
  output logic            cs_n,
  output logic            sclk,
  input  logic [NCH-1:0]  sdata,
  output logic [DW-1:0]   ad_data,
  output logic [CHW-1:0]  ad_ch,
  output logic            ad_vld,
  input  logic            ad_rdy,
  input  logic [21:0]     fx_waddr,
  input  logic            fx_wr,
  input  logic [7:0]      fx_data,
  input  logic [21:0]     fx_raddr,
  input  logic            fx_rd,
  output logic [7:0]      fx_q,
  input  logic [5:0]      dev_id
);

  localparam int unsigned BW     = $clog2(FRAME_BITS + 1);
  localparam logic [15:0] ChMask = 16'((32'd1 << NCH) - 32'd1);

  logic        run_q, miss_q;
  logic [15:0] ch_en_q, period_q, ovf_q, per_cnt_q;
  logic [7:0]  sclk_div_q;
  logic [15:0] per_eff;
  logic [7:0]  div_eff;
  logic        tick, half_done, sample_en, load_en;

  frame_state_e   state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic           phase_q, phase_d;

  logic [DW-1:0]  shreg_q [NCH];
  logic [DW-1:0]  hold_q  [NCH];
  logic [NCH-1:0] hvld_q, hvld_d, ovf_set_n;

  logic           out_vld_q, out_load;
  logic [DW-1:0]  out_data_q, gnt_data;
  logic [CHW-1:0] out_ch_q, ptr_q, ptr_nxt, gnt;
  logic           gnt_any;

  logic       wsel, rsel, clr_ovf;
  logic [7:0] woff, roff, rdata;
  logic       unused_addr;

  assign unused_addr = ^{fx_waddr[15:8], fx_raddr[15:8]};

  assign per_eff   = (period_q == '0) ? 16'd1 : period_q;
  assign div_eff   = (sclk_div_q == '0) ? 8'd1 : sclk_div_q;
  assign tick      = run_q && (per_cnt_q >= per_eff - 16'd1);
  assign half_done = (cnt_q >= div_eff - 8'd1);
  assign sample_en = (state_q == StShift) && half_done && !phase_q;
  assign load_en   = (state_q == StLoad);

  // fx register file
  assign wsel    = fx_wr && (fx_waddr[21:16] == dev_id);
  assign woff    = fx_waddr[7:0];
  assign rsel    = fx_rd && (fx_raddr[21:16] == dev_id);
  assign roff    = fx_raddr[7:0];
  assign clr_ovf = wsel && (woff == RegCtrl) && fx_data[1];

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      run_q      <= 1'b0;
      ch_en_q    <= '0;
      period_q   <= PERIOD_RST;
      sclk_div_q <= SCLK_DIV_RST;
      ovf_q      <= '0;
      miss_q     <= 1'b0;
    end else begin
      if (wsel) begin
        case (woff)
          RegCtrl:     run_q            <= fx_data[0];
          RegChEnLo:   ch_en_q[7:0]     <= fx_data & ChMask[7:0];
          RegChEnHi:   ch_en_q[15:8]    <= fx_data & ChMask[15:8];
          RegPeriodLo: period_q[7:0]    <= fx_data;
          RegPeriodHi: period_q[15:8]   <= fx_data;
          RegSclkDiv:  sclk_div_q       <= fx_data;
          default: ;
        endcase
      end
      if (clr_ovf) begin
        ovf_q  <= '0;
        miss_q <= 1'b0;
      end else begin
        ovf_q <= ovf_q | 16'(ovf_set_n);
        if (tick && (state_q != StIdle)) miss_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (roff)
      RegCtrl:     rdata = {7'd0, run_q};
      RegChEnLo:   rdata = ch_en_q[7:0];
      RegChEnHi:   rdata = ch_en_q[15:8];
      RegPeriodLo: rdata = period_q[7:0];
      RegPeriodHi: rdata = period_q[15:8];
      RegOvfLo:    rdata = ovf_q[7:0];
      RegOvfHi:    rdata = ovf_q[15:8];
      RegSclkDiv:  rdata = sclk_div_q;
      RegStat:     rdata = {6'd0, miss_q, state_q != StIdle};
      RegInfo:     rdata = 8'(NCH);
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) fx_q <= '0;
    else     fx_q <= rsel ? rdata : 8'd0;
  end

  always_ff @(posedge clk_sys) begin
    if (rst || !run_q || tick) per_cnt_q <= '0;
    else                       per_cnt_q <= per_cnt_q + 16'd1;
  end

  // Frame FSM: state register
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
    end
  end

  // Frame FSM: next state. phase 0 = sclk low half, 1 = sclk high half.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StSetup;
          cnt_d   = '0;
        end
      end
      StSetup: begin
        if (half_done) begin
          state_d = StShift;
          cnt_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StShift: begin
        if (half_done) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (bit_q == BW'(FRAME_BITS - 1)) begin
            state_d = StHold;
          end else begin
            phase_d = 1'b0;
            bit_d   = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (half_done) begin
          state_d = StLoad;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StLoad:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Frame FSM: outputs
  always_comb begin
    cs_n = 1'b1;
    sclk = 1'b1;
    case (state_q)
      StSetup: cs_n = 1'b0;
      StShift: begin
        cs_n = 1'b0;
        sclk = phase_q;
      end
      default: ;
    endcase
  end

  ad_rr_arb #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_arb (
    .req   (hvld_q),
    .start (ptr_q),
    .gnt   (gnt),
    .any   (gnt_any)
  );

  assign out_load = !out_vld_q || ad_rdy;
  // Pointer holds the channel after the last grant, so after reset ch0 leads.
  assign ptr_nxt  = (gnt == CHW'(NCH - 1)) ? '0 : gnt + CHW'(1);

  // A drain and a LOAD of the same channel: old value leaves, new one stays, no overflow.
  always_comb begin
    hvld_d    = hvld_q;
    ovf_set_n = '0;
    gnt_data  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gnt == CHW'(i)) gnt_data = hold_q[i];
      if (load_en && ch_en_q[i]) begin
        hvld_d[i] = 1'b1;
        if (hvld_q[i] && !(out_load && gnt_any && gnt == CHW'(i))) ovf_set_n[i] = 1'b1;
      end else if (out_load && gnt_any && gnt == CHW'(i)) begin
        hvld_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        shreg_q[i] <= '0;
        hold_q[i]  <= '0;
      end
      hvld_q     <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      ptr_q      <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (sample_en) shreg_q[i] <= {shreg_q[i][DW-2:0], sdata[i]};
        if (load_en && ch_en_q[i]) hold_q[i] <= shreg_q[i];
      end
      hvld_q <= hvld_d;
      if (out_load) begin
        out_vld_q <= gnt_any;
        if (gnt_any) begin
          out_data_q <= gnt_data;
          out_ch_q   <= gnt;
          ptr_q      <= ptr_nxt;
        end
      end
    end
  end

  assign ad_vld  = out_vld_q;
  assign ad_data = out_data_q;
  assign ad_ch   = out_ch_q;

endmodule

// File: tb/tb_ad_multi_ch.sv
// Self-checking bench for ad_multi_ch: register table, serial ADC model and a
// stream scoreboard driven from per-frame captured words.
module tb_ad_multi_ch;
  import ad_multi_pkg::*;

  localparam int unsigned NCH = 8;
  localparam int unsigned FB  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned CHW = 4;
  localparam logic [5:0]  DEV = 6'h2A;

  typedef logic [NCH-1:0][15:0] frame_t;

  logic            clk_sys = 1'b0;
  logic            rst = 1'b1;
  logic            cs_n, sclk;
  logic [NCH-1:0]  sdata = '0;
  logic [DW-1:0]   ad_data;
  logic [CHW-1:0]  ad_ch;
  logic            ad_vld;
  logic            ad_rdy = 1'b0;
  logic [21:0]     fx_waddr = '0;
  logic            fx_wr = 1'b0;
  logic [7:0]      fx_data = '0;
  logic [21:0]     fx_raddr = '0;
  logic            fx_rd = 1'b0;
  logic [7:0]      fx_q;

  always #5 clk_sys = ~clk_sys;

  ad_multi_ch #(
    .NCH        (NCH),
    .FRAME_BITS (FB),
    .DW         (DW),
    .CHW        (CHW)
  ) dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .cs_n     (cs_n),
    .sclk     (sclk),
    .sdata    (sdata),
    .ad_data  (ad_data),
    .ad_ch    (ad_ch),
    .ad_vld   (ad_vld),
    .ad_rdy   (ad_rdy),
    .fx_waddr (fx_waddr),
    .fx_wr    (fx_wr),
    .fx_data  (fx_data),
    .fx_raddr (fx_raddr),
    .fx_rd    (fx_rd),
    .fx_q     (fx_q),
    .dev_id   (DEV)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // ADC model: MSB driven on the first sclk fall after cs_n falls
  frame_t adc_word;
  int     bit_idx = 0;
  always @(negedge cs_n) bit_idx = 0;
  always @(negedge sclk) begin
    if (!cs_n && bit_idx < FB) begin
      for (int c = 0; c < NCH; c++) sdata[c] = adc_word[c][FB-1-bit_idx];
      bit_idx++;
    end
  end

  int rise_cnt = 0;
  always @(posedge sclk) if (!cs_n) rise_cnt++;

  // Scoreboard state
  int           low_cnt = 0, frame_cnt = 0, stab_viol = 0;
  int           lows[$], rises[$];
  frame_t       frames[$];
  logic [19:0]  got[$], expq[$];
  logic [NCH-1:0] chen_m = '0;
  int           model_ptr = 0;
  bit           model_on = 0;
  logic         prev_stall = 1'b0;
  logic [DW-1:0]  prev_data = '0;
  logic [CHW-1:0] prev_ch = '0;

  // Each enabled channel emits once per frame, round-robin after the last one served.
  task automatic model_frame(input frame_t w);
    int last;
    last = -1;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (model_ptr + k) % NCH;
      if (chen_m[c]) begin
        expq.push_back({4'(c), w[c]});
        last = c;
      end
    end
    if (last >= 0) model_ptr = (last + 1) % NCH;
  endtask

  always @(negedge clk_sys) begin
    if (!cs_n) begin
      low_cnt++;
    end else if (low_cnt != 0) begin
      lows.push_back(low_cnt);
      rises.push_back(rise_cnt);
      low_cnt  = 0;
      rise_cnt = 0;
      frame_cnt++;
      frames.push_back(adc_word);
      if (model_on) model_frame(adc_word);
      for (int c = 0; c < NCH; c++) adc_word[c] = 16'($urandom);
    end
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(ad_vld && ad_data == prev_data && ad_ch == prev_ch)) stab_viol++;
      if (ad_vld && ad_rdy) got.push_back({ad_ch, ad_data});
      prev_stall = ad_vld && !ad_rdy;
      prev_data  = ad_data;
      prev_ch    = ad_ch;
    end
  end

  int   rdy_mode = 0;
  logic rdy_fix = 1'b1;
  initial forever begin
    @(posedge clk_sys);
    #1;
    case (rdy_mode)
      0:       ad_rdy = rdy_fix;
      1:       ad_rdy = ~ad_rdy;
      default: ad_rdy = 1'($urandom);
    endcase
  end

  task automatic fx_write(input logic [5:0] id, input logic [7:0] off, input logic [7:0] d);
    fx_waddr = {id, 8'h3C, off};
    fx_data  = d;
    fx_wr    = 1'b1;
    step();
    fx_wr = 1'b0;
  endtask

  task automatic fx_read(input logic [5:0] id, input logic [7:0] off, output logic [7:0] q);
    fx_raddr = {id, 8'hC3, off};
    fx_rd    = 1'b1;
    step();
    fx_rd = 1'b0;
    q     = fx_q;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    lows.delete(); rises.delete(); frames.delete(); got.delete(); expq.delete();
    frame_cnt = 0; stab_viol = 0; model_ptr = 0; model_on = 0;
  endtask

  task automatic setup(input logic [7:0] chen, input logic [7:0] div, input logic [15:0] per);
    fx_write(DEV, RegChEnLo, chen);
    fx_write(DEV, RegSclkDiv, div);
    fx_write(DEV, RegPeriodLo, per[7:0]);
    fx_write(DEV, RegPeriodHi, per[15:8]);
    chen_m = chen;
  endtask

  task automatic wait_frames(input string name, input int n, input int budget);
    int target, k;
    target = frame_cnt + n;
    k = 0;
    while (frame_cnt < target && k < budget) begin
      step();
      k++;
    end
    chk({name, "_frame_timeout"}, 32'(frame_cnt >= target), 1);
  endtask

  task automatic wait_cs_low(input string name, input int budget);
    int k;
    k = 0;
    while (cs_n && k < budget) begin
      step();
      k++;
    end
    chk({name, "_cs_timeout"}, 32'(cs_n), 0);
  endtask

  task automatic cmp_stream(input string name);
    chk({name, "_beats"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      chk($sformatf("%s_beat%0d", name, i), got[i], expq[i]);
    got.delete();
    expq.delete();
  endtask

  typedef struct {
    string      name;
    bit         wr;
    logic [5:0] wid;
    logic [5:0] rid;
    logic [7:0] off;
    logic [7:0] wd;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] q;

  initial begin
    for (int c = 0; c < NCH; c++) adc_word[c] = 16'($urandom);
    step(2);
    rst = 1'b0;
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_ad_vld", ad_vld, 0);
    chk("rst_ad_data", ad_data, 0);
    chk("rst_ad_ch", ad_ch, 0);
    chk("rst_fx_q", fx_q, 0);

    vecs = '{
      '{"info",       0, DEV,   DEV,   RegInfo,     8'h00, 8'h08},
      '{"period_lo",  0, DEV,   DEV,   RegPeriodLo, 8'h00, 8'hE8},
      '{"period_hi",  0, DEV,   DEV,   RegPeriodHi, 8'h00, 8'h03},
      '{"sclk_div",   0, DEV,   DEV,   RegSclkDiv,  8'h00, 8'h01},
      '{"ctrl",       0, DEV,   DEV,   RegCtrl,     8'h00, 8'h00},
      '{"stat",       0, DEV,   DEV,   RegStat,     8'h00, 8'h00},
      '{"ovf_lo",     0, DEV,   DEV,   RegOvfLo,    8'h00, 8'h00},
      '{"unmapped",   0, DEV,   DEV,   8'h0A,       8'h00, 8'h00},
      '{"wrong_id",   0, DEV,   6'h15, RegInfo,     8'h00, 8'h00},
      '{"chen_hi",    1, DEV,   DEV,   RegChEnHi,   8'hFF, 8'h00},
      '{"chen_lo",    1, DEV,   DEV,   RegChEnLo,   8'hA5, 8'hA5},
      '{"div_wr",     1, DEV,   DEV,   RegSclkDiv,  8'h07, 8'h07},
      '{"div_wrong",  1, 6'h15, DEV,   RegSclkDiv,  8'h09, 8'h07},
      '{"period_wr",  1, DEV,   DEV,   RegPeriodLo, 8'h34, 8'h34},
      '{"ctrl_clr",   1, DEV,   DEV,   RegCtrl,     8'h03, 8'h01}
    };
    foreach (vecs[i]) begin
      if (vecs[i].wr) fx_write(vecs[i].wid, vecs[i].off, vecs[i].wd);
      fx_read(vecs[i].rid, vecs[i].off, q);
      chk({"reg_", vecs[i].name}, q, vecs[i].exp);
    end

    // Two enabled channels, ready always high
    do_reset();
    setup(8'h05, 8'd2, 16'd200);
    rdy_mode = 0; rdy_fix = 1'b1;
    adc_word[0] = 16'hA5C3;
    adc_word[2] = 16'h1234;
    model_on = 1;
    fx_write(DEV, RegCtrl, 8'h01);
    wait_frames("A", 1, 1000);
    step(10);
    fx_write(DEV, RegCtrl, 8'h00);
    step(20);
    chk("A_cs_low", lows.size() > 0 ? lows[0] : 0, 66);
    chk("A_rises", rises.size() > 0 ? rises[0] : 0, 16);
    chk("A_first", got.size() > 0 ? 32'(got[0]) : 32'hFFFFFFFF, {12'd0, 4'd0, 16'hA5C3});
    chk("A_second", got.size() > 1 ? 32'(got[1]) : 32'hFFFFFFFF, {12'd0, 4'd2, 16'h1234});
    cmp_stream("A");

    // Stalled output: overflow on repeated frames, newest value wins
    do_reset();
    setup(8'h05, 8'd2, 16'd200);
    rdy_fix = 1'b0;
    step(2);
    fx_write(DEV, RegCtrl, 8'h01);
    wait_frames("B", 3, 2000);
    step(10);
    fx_write(DEV, RegCtrl, 8'h00);
    fx_read(DEV, RegOvfLo, q);
    chk("B_ovf_lo", q, 8'h05);
    fx_read(DEV, RegOvfHi, q);
    chk("B_ovf_hi", q, 8'h00);
    chk("B_vld", ad_vld, 1);
    chk("B_ch", ad_ch, 0);
    chk("B_data", ad_data, frames.size() > 0 ? frames[0][0] : 16'h0);
    if (frames.size() >= 3) begin
      expq.push_back({4'd0, frames[0][0]});
      expq.push_back({4'd2, frames[2][2]});
      expq.push_back({4'd0, frames[2][0]});
    end
    rdy_fix = 1'b1;
    step(10);
    cmp_stream("B");
    chk("B_stable", stab_viol, 0);
    fx_write(DEV, RegCtrl, 8'h02);
    fx_read(DEV, RegOvfLo, q);
    chk("B_ovf_clr", q, 8'h00);

    // All channels, ready toggling
    do_reset();
    setup(8'hFF, 8'd1, 16'd120);
    rdy_mode = 1;
    model_on = 1;
    fx_write(DEV, RegCtrl, 8'h01);
    wait_frames("C", 3, 2000);
    step(30);
    fx_write(DEV, RegCtrl, 8'h00);
    step(30);
    cmp_stream("C");
    chk("C_stable", stab_viol, 0);

    // Random channel masks, divisors and ready pattern
    rdy_mode = 2;
    for (int it = 0; it < 3; it++) begin
      setup(8'($urandom), 8'($urandom_range(3, 1)), 16'd220);
      fx_write(DEV, RegCtrl, 8'h01);
      wait_frames("R", 3, 3000);
      step(20);
      fx_write(DEV, RegCtrl, 8'h00);
      step(300);
      cmp_stream($sformatf("R%0d", it));
    end
    chk("R_stable", stab_viol, 0);

    // Period shorter than a frame: ticks dropped, frames never overlap
    rdy_mode = 0; rdy_fix = 1'b1;
    do_reset();
    setup(8'h00, 8'd2, 16'd10);
    fx_write(DEV, RegCtrl, 8'h01);
    wait_frames("D", 4, 2000);
    fx_write(DEV, RegCtrl, 8'h00);
    step(100);
    fx_read(DEV, RegStat, q);
    chk("D_miss", q & 8'h02, 8'h02);
    foreach (lows[i]) chk($sformatf("D_cs_low%0d", i), lows[i], 66);

    // Clearing run mid-shift lets the frame complete
    do_reset();
    setup(8'h05, 8'd2, 16'd200);
    fx_write(DEV, RegCtrl, 8'h01);
    wait_cs_low("E", 400);
    step(30);
    fx_write(DEV, RegCtrl, 8'h00);
    step(400);
    chk("E_frames", frame_cnt, 1);
    chk("E_cs_low", lows.size() > 0 ? lows[0] : 0, 66);
    chk("E_rises", rises.size() > 0 ? rises[0] : 0, 16);
    chk("E_beats", got.size(), 2);

    // Reset mid-shift aborts at once with no sample
    do_reset();
    setup(8'h05, 8'd2, 16'd200);
    fx_write(DEV, RegCtrl, 8'h01);
    wait_cs_low("F", 400);
    step(30);
    rst = 1'b1;
    step();
    chk("F_cs_n", cs_n, 1);
    chk("F_sclk", sclk, 1);
    rst = 1'b0;
    step(300);
    chk("F_no_beats", got.size(), 0);
    chk("F_vld", ad_vld, 0);
    fx_read(DEV, RegStat, q);
    chk("F_stat", q, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
